// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of the pipelined RV32 core. Owns the fetch PC,
//   keeps at most one request in flight to instruction memory, parks a
//   returned word while decode is stalled, and applies branch/jump redirects
//   coming back from execute. Instr / PC / PC_plus_4 are the IF/ID register.
//
// Ports
//   clk          in   clock, all state changes on posedge
//   reset        in   asynchronous, active-low reset
//   EN           in   decode enable from hazard unit (0 = stall IF/ID)
//   PCSrc        in   redirect request from execute
//   PCTarget     in   redirect address (bits [1:0] ignored)
//   imem_req     out  request valid
//   imem_addr    out  request address (word aligned)
//   imem_ready   in   memory accepts request this cycle
//   imem_rvalid  in   response valid
//   imem_rdata   in   response word
//   Instr        out  IF/ID instruction
//   PC           out  IF/ID address of Instr
//   PC_plus_4    out  IF/ID PC + 4
// ----------------------------------------------------------------------------
module fetch_stage #(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter logic [DATA_W-1:0] NOP      = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              EN,
  input  logic              PCSrc,
  input  logic [DATA_W-1:0] PCTarget,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] Instr,
  output logic [DATA_W-1:0] PC,
  output logic [DATA_W-1:0] PC_plus_4
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] fetch_pc;
  logic [DATA_W-1:0] req_pc;
  logic [DATA_W-1:0] hold_instr;
  logic              discard;

  logic              deliver;
  logic [DATA_W-1:0] deliver_word;

  // Sequential PC step; wraps modulo 2^DATA_W.
  function automatic logic [DATA_W-1:0] pc_inc(input logic [DATA_W-1:0] pc);
    return pc + DATA_W'(4);
  endfunction

  // Redirect targets are forced onto a word boundary.
  function automatic logic [DATA_W-1:0] word_align(input logic [DATA_W-1:0] a);
    return a & ~DATA_W'(3);
  endfunction

  // Request side: held low through reset even though state already reads REQ.
  assign imem_req  = reset && (state == S_REQ);
  assign imem_addr = fetch_pc;

  // A word reaches IF/ID only when decode takes it and no redirect kills it.
  always_comb begin
    deliver      = 1'b0;
    deliver_word = imem_rdata;
    if (state == S_HOLD) deliver_word = hold_instr;
    if (!PCSrc && EN) begin
      case (state)
        S_WAIT:  deliver = imem_rvalid && !discard;
        S_HOLD:  deliver = 1'b1;
        default: deliver = 1'b0;
      endcase
    end
  end

  // Fetch control FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_REQ;
      fetch_pc   <= RESET_PC;
      req_pc     <= RESET_PC;
      hold_instr <= NOP;
      discard    <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          // Any response seen here is a protocol error and is ignored.
          if (imem_ready) begin
            req_pc  <= fetch_pc;
            state   <= S_WAIT;
            // Request just issued is for the old path if a redirect lands now.
            discard <= PCSrc;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (discard || PCSrc) begin
              discard <= 1'b0;
              state   <= S_REQ;
            end else if (EN) begin
              fetch_pc <= pc_inc(req_pc);
              state    <= S_REQ;
            end else begin
              hold_instr <= imem_rdata;
              state      <= S_HOLD;
            end
          end else if (PCSrc) begin
            // Must still drain the stale response before issuing the target.
            discard <= 1'b1;
          end
        end
        S_HOLD: begin
          if (PCSrc) begin
            state <= S_REQ;
          end else if (EN) begin
            fetch_pc <= pc_inc(req_pc);
            state    <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
      // Redirect wins over the sequential PC update above.
      if (PCSrc) fetch_pc <= word_align(PCTarget);
    end
  end

  // IF/ID pipeline register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Instr     <= NOP;
      PC        <= '0;
      PC_plus_4 <= '0;
    end else if (PCSrc) begin
      Instr     <= NOP;
      PC        <= '0;
      PC_plus_4 <= '0;
    end else if (EN) begin
      if (deliver) begin
        Instr     <= deliver_word;
        PC        <= req_pc;
        PC_plus_4 <= pc_inc(req_pc);
      end else begin
        Instr     <= NOP;
        PC        <= '0;
        PC_plus_4 <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] N  = 32'h0000_0013;
  localparam logic [31:0] I0 = 32'h0050_0093;
  localparam logic [31:0] I1 = 32'h0010_8113;
  localparam logic [31:0] W8 = 32'h0020_0193;

  logic        clk = 1'b0;
  logic        reset;
  logic        EN;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PC_plus_4;

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .EN         (EN),
    .PCSrc      (PCSrc),
    .PCTarget   (PCTarget),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .Instr      (Instr),
    .PC         (PC),
    .PC_plus_4  (PC_plus_4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic        pcs;
    logic [31:0] tgt;
    logic        rdy;
    logic        rv;
    logic [31:0] rdata;
    logic        ereq;   // imem_req before the edge
    logic [31:0] eaddr;  // imem_addr before the edge
    logic [31:0] ei;     // IF/ID after the edge
    logic [31:0] epc;
    logic [31:0] epc4;
  } vec_t;

  vec_t tbl[$];
  int   total  = 0;
  int   passed = 0;

  function automatic void add(input logic rst, input logic en, input logic pcs,
                              input logic [31:0] tgt, input logic rdy, input logic rv,
                              input logic [31:0] rdata, input logic ereq,
                              input logic [31:0] eaddr, input logic [31:0] ei,
                              input logic [31:0] epc, input logic [31:0] epc4);
    vec_t v;
    v.rst = rst; v.en = en; v.pcs = pcs; v.tgt = tgt; v.rdy = rdy; v.rv = rv;
    v.rdata = rdata; v.ereq = ereq; v.eaddr = eaddr; v.ei = ei; v.epc = epc;
    v.epc4 = epc4;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    reset = 1'b1; EN = 1'b1; PCSrc = 1'b0; PCTarget = '0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    #1 reset = 1'b0;

    //   rst en pcs tgt            rdy rv rdata          req addr           Instr          PC             PC+4
    // reset
    add(0, 1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         N,             32'h0,         32'h0);
    // zero-wait stream
    add(1, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0,         N,             32'h0,         32'h0);
    add(1, 1, 0, 32'h0,         0, 1, I0,            0, 32'h0,         I0,            32'h0,         32'h4);
    add(1, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h4,         N,             32'h0,         32'h0);
    add(1, 1, 0, 32'h0,         0, 1, I1,            0, 32'h4,         I1,            32'h4,         32'h8);
    add(1, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h8,         N,             32'h0,         32'h0);
    add(1, 1, 0, 32'h0,         0, 1, W8,            0, 32'h8,         W8,            32'h8,         32'hC);
    // reset again, then stall while the 0x4 response arrives
    add(0, 1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         N,             32'h0,         32'h0);
    add(1, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0,         N,             32'h0,         32'h0);
    add(1, 1, 0, 32'h0,         0, 1, I0,            0, 32'h0,         I0,            32'h0,         32'h4);
    add(1, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h4,         N,             32'h0,         32'h0);
    add(1, 0, 0, 32'h0,         0, 1, I1,            0, 32'h4,         N,             32'h0,         32'h0);
    add(1, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h4,         N,             32'h0,         32'h0);
    add(1, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h4,         N,             32'h0,         32'h0);
    add(1, 1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h4,         I1,            32'h4,         32'h8);
    add(1, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h8,         N,             32'h0,         32'h0);
    // redirect to 0x103 while waiting for 0x8, stale response two cycles later
    add(1, 1, 1, 32'h103,       0, 0, 32'h0,         0, 32'h8,         N,             32'h0,         32'h0);
    add(1, 1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h100,       N,             32'h0,         32'h0);
    add(1, 1, 0, 32'h0,         0, 1, W8,            0, 32'h100,       N,             32'h0,         32'h0);
    add(1, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h100,       N,             32'h0,         32'h0);
    add(1, 1, 0, 32'h0,         0, 1, 32'h00A00293,  0, 32'h100,       32'h00A00293,  32'h100,       32'h104);
    // redirect and response in the same WAIT cycle
    add(1, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h104,       N,             32'h0,         32'h0);
    add(1, 1, 1, 32'h200,       0, 1, 32'hBAD00104,  0, 32'h104,       N,             32'h0,         32'h0);
    // memory not ready for 4 cycles
    add(1, 1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h200,       N,             32'h0,         32'h0);
    add(1, 1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h200,       N,             32'h0,         32'h0);
    add(1, 1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h200,       N,             32'h0,         32'h0);
    add(1, 1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h200,       N,             32'h0,         32'h0);
    add(1, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h200,       N,             32'h0,         32'h0);
    add(1, 1, 0, 32'h0,         0, 1, 32'h00000513,  0, 32'h200,       32'h00000513,  32'h200,       32'h204);
    // redirect in REQ without ready, target at top of address space
    add(1, 1, 1, 32'hFFFFFFFC,  0, 0, 32'h0,         1, 32'h204,       N,             32'h0,         32'h0);
    add(1, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'hFFFFFFFC,  N,             32'h0,         32'h0);
    add(1, 1, 0, 32'h0,         0, 1, 32'h0000006F,  0, 32'hFFFFFFFC,  32'h0000006F,  32'hFFFFFFFC,  32'h0);
    // spurious response in REQ is ignored
    add(1, 1, 0, 32'h0,         0, 1, 32'hBAD0BAD0,  1, 32'h0,         N,             32'h0,         32'h0);
    // redirect together with accept in REQ
    add(1, 1, 1, 32'h300,       1, 0, 32'h0,         1, 32'h0,         N,             32'h0,         32'h0);
    add(1, 1, 0, 32'h0,         0, 1, 32'hBAD00000,  0, 32'h300,       N,             32'h0,         32'h0);
    add(1, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h300,       N,             32'h0,         32'h0);
    // redirect while holding a word
    add(1, 0, 0, 32'h0,         0, 1, 32'hBAD00300,  0, 32'h300,       N,             32'h0,         32'h0);
    add(1, 0, 1, 32'h400,       0, 0, 32'h0,         0, 32'h300,       N,             32'h0,         32'h0);
    add(1, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h400,       N,             32'h0,         32'h0);
    add(1, 1, 0, 32'h0,         0, 1, 32'h00400413,  0, 32'h400,       32'h00400413,  32'h400,       32'h404);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset = tbl[i].rst; EN = tbl[i].en; PCSrc = tbl[i].pcs; PCTarget = tbl[i].tgt;
      imem_ready = tbl[i].rdy; imem_rvalid = tbl[i].rv; imem_rdata = tbl[i].rdata;
      #1;
      chk($sformatf("row%0d imem_req", i), {31'b0, imem_req}, {31'b0, tbl[i].ereq});
      chk($sformatf("row%0d imem_addr", i), imem_addr, tbl[i].eaddr);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d Instr", i), Instr, tbl[i].ei);
      chk($sformatf("row%0d PC", i), PC, tbl[i].epc);
      chk($sformatf("row%0d PC_plus_4", i), PC_plus_4, tbl[i].epc4);
    end

    // Asynchronous reset while a request is outstanding
    @(negedge clk);
    EN = 1'b0; PCSrc = 1'b0; imem_ready = 1'b1; imem_rvalid = 1'b0;
    @(posedge clk);
    #1;
    chk("wait_accept imem_req", {31'b0, imem_req}, 32'h0);
    chk("wait_hold Instr", Instr, 32'h00400413);
    #2 reset = 1'b0;
    #1;
    chk("async_rst Instr", Instr, N);
    chk("async_rst PC", PC, 32'h0);
    chk("async_rst PC_plus_4", PC_plus_4, 32'h0);
    chk("async_rst imem_req", {31'b0, imem_req}, 32'h0);
    chk("async_rst imem_addr", imem_addr, 32'h0);
    @(negedge clk);
    reset = 1'b1; EN = 1'b1; imem_ready = 1'b0;
    #1;
    chk("post_rst imem_req", {31'b0, imem_req}, 32'h1);
    chk("post_rst imem_addr", imem_addr, 32'h0);
    @(negedge clk);
    imem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = I0;
    #1;
    chk("post_rst wait imem_req", {31'b0, imem_req}, 32'h0);
    @(posedge clk);
    #1;
    chk("post_rst Instr", Instr, I0);
    chk("post_rst PC", PC, 32'h0);
    chk("post_rst PC_plus_4", PC_plus_4, 32'h4);
    chk("post_rst next addr", imem_addr, 32'h4);
    @(negedge clk);
    imem_rvalid = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
